// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the four-way index arbiter and
// the downstream 2-to-4 decoder.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner select: rotate so the slot after last_ptr is bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pick;

    assign start = last_ptr + 1'b1;

    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + start];
        end
    end

    // Scan downwards so the lowest set bit wins.
    always_comb begin
        pick = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                pick = IDX_W'(i - 1);
            end
        end
    end

    assign any    = |req;
    assign winner = pick + start;

endmodule

// File: rtl/rr_arbiter4_idx.sv
// Four-requester round-robin arbiter with registered grant index, valid flag
// and a one-cycle pulse when a grant is cut off by the hold-time limit.
module rr_arbiter4_idx
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic                 done,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid,
    output logic                 timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  last_ptr;
    logic [CNT_W-1:0]  hold_cnt;
    logic              any;
    logic [IDX_W-1:0]  winner;

    rr_pick4 u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .any      (any),
        .winner   (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            last_ptr    <= '1;
            hold_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state       <= GRANT;
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        last_ptr    <= winner;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    // Voluntary release outranks the hold limit, so a release on
                    // the final allowed cycle never reports a timeout.
                    if (done || !req[grant_idx]) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4_idx.sv
// Directed bench for rr_arbiter4_idx; observed vector is
// {grant_valid, grant_idx, timeout}.
module tb_rr_arbiter4_idx;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    logic [3:0] obs;

    int checks;
    int errors;

    rr_arbiter4_idx #(.MAX_HOLD(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    assign obs = {grant_valid, grant_idx, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        req   = 4'b1111;
        done  = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_immediate: got %b expected %b", obs, 4'b0000);
        end
        tick();
        tick();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", obs, 4'b0000);
        end
        req   = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: got %b expected %b", i, obs, 4'b0000);
            end
        end
    endtask

    task automatic test_single;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (obs !== exp_seq[c-1]) begin
                errors++;
                $display("FAIL single cycle %0d: got %b expected %b", c, obs, exp_seq[c-1]);
            end
            done = (c == 3);
        end
        done = 1'b0;
        req  = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        logic [1:0] k;
        reset_dut();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            k = 2'(i % 4);
            tick();
            checks++;
            if (obs !== {1'b1, k, 1'b0}) begin
                errors++;
                $display("FAIL rr_grant %0d: got %b expected %b", i, obs, {1'b1, k, 1'b0});
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (obs !== {1'b0, k, 1'b0}) begin
                errors++;
                $display("FAIL rr_bubble %0d: got %b expected %b", i, obs, {1'b0, k, 1'b0});
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout;
        reset_dut();
        req = 4'b0100;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checks++;
            if (obs !== 4'b1100) begin
                errors++;
                $display("FAIL hold cycle %0d: got %b expected %b", c, obs, 4'b1100);
            end
        end
        tick();
        checks++;
        if (obs !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_pulse: got %b expected %b", obs, 4'b0101);
        end
        tick();
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL regrant_after_timeout: got %b expected %b", obs, 4'b1100);
        end
        // Others start requesting mid-grant: owner keeps the grant to the limit.
        req = 4'b1111;
        for (int c = 2; c <= 15; c++) begin
            tick();
            checks++;
            if (obs !== 4'b1100) begin
                errors++;
                $display("FAIL hold2 cycle %0d: got %b expected %b", c, obs, 4'b1100);
            end
        end
        tick();
        checks++;
        if (obs !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_pulse2: got %b expected %b", obs, 4'b0101);
        end
        tick();
        checks++;
        if (obs !== 4'b1110) begin
            errors++;
            $display("FAIL fair_next3: got %b expected %b", obs, 4'b1110);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (obs !== 4'b0110) begin
            errors++;
            $display("FAIL fair_bubble: got %b expected %b", obs, 4'b0110);
        end
        tick();
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL fair_next0: got %b expected %b", obs, 4'b1000);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_req_drop;
        reset_dut();
        req = 4'b0010;
        tick();
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL drop_grant: got %b expected %b", obs, 4'b1010);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (obs !== 4'b0010) begin
            errors++;
            $display("FAIL drop_release: got %b expected %b", obs, 4'b0010);
        end
        req = 4'b0010;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checks++;
            if (obs !== 4'b1010) begin
                errors++;
                $display("FAIL done_hold cycle %0d: got %b expected %b", c, obs, 4'b1010);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (obs !== 4'b0010) begin
            errors++;
            $display("FAIL done_at_limit: got %b expected %b", obs, 4'b0010);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset;
        reset_dut();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL pre_abort_grant: got %b expected %b", obs, 4'b1100);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL async_abort: got %b expected %b", obs, 4'b0000);
        end
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL post_reset_first: got %b expected %b", obs, 4'b1000);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_req_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
